perceptron_classifier: RTL and testbench

Inference stage downstream of the training top (`CA_CA1`). It latches the trained 14-bit weights `w1`, `w2` and bias `b` when training reports `ready`. It then classifies a stream of samples (x1, x2) as sign(w1·x1 + w2·x2 + b) through a 2-stage pipeline with valid/ready handshakes on both sides. It also keeps saturating counts of classified and positive samples.

---
 rtl/perceptron_classifier.sv | 100 ++++++++++
 tb/tb_perceptron_classifier.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_classifier.sv
// Perceptron inference: latches trained weights, then classifies (x1, x2) samples
// as sign(w1*x1 + w2*x2 + b) through a two-stage valid/ready pipeline.
module perceptron_classifier #(
   parameter int W    = 14,
   parameter int FRAC = 11,
   parameter int CW   = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_w,
   input  logic [W-1:0]    w1_in,
   input  logic [W-1:0]    w2_in,
   input  logic [W-1:0]    b_in,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    x1,
   input  logic [W-1:0]    x2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            y,
   output logic [2*W+1:0]  sum,
   output logic            loaded,
   output logic [CW-1:0]   sample_cnt,
   output logic [CW-1:0]   pos_cnt
);

   typedef enum logic {EMPTY = 1'b0, LOADED = 1'b1} state_t;

   state_t                state;
   logic [W-1:0]          w1, w2, b;
   logic                  s1_v, s2_v;
   logic signed [2*W-1:0] p1, p2, prod1, prod2;
   logic signed [2*W+1:0] bsh, bsh_c, sum_c;
   logic                  s1_load, s2_load, accept, handshake;

   // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
   // in_ready is combinational so it rises in the same cycle out_ready frees the pipe.
   assign s2_load   = !s2_v || out_ready;
   assign s1_load   = !s1_v || s2_load;
   assign in_ready  = (state == LOADED) && !load_w && s1_load;
   assign accept    = in_valid && in_ready;
   assign handshake = s2_v && out_ready;
   assign out_valid = s2_v;
   assign loaded    = (state == LOADED);

   assign prod1 = $signed({{W{w1[W-1]}}, w1}) * $signed({{W{x1[W-1]}}, x1});
   assign prod2 = $signed({{W{w2[W-1]}}, w2}) * $signed({{W{x2[W-1]}}, x2});
   assign bsh_c = $signed({{(W+2){b[W-1]}}, b}) <<< FRAC;
   // Two guard bits: |p1|,|p2| <= 2^(2W-2) and |b<<FRAC| < 2^(2W-2), so no overflow.
   assign sum_c = {{2{p1[2*W-1]}}, p1} + {{2{p2[2*W-1]}}, p2} + bsh;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= EMPTY;
         w1         <= '0;
         w2         <= '0;
         b          <= '0;
         s1_v       <= 1'b0;
         s2_v       <= 1'b0;
         p1         <= '0;
         p2         <= '0;
         bsh        <= '0;
         sum        <= '0;
         y          <= 1'b0;
         sample_cnt <= '0;
         pos_cnt    <= '0;
      end else if (load_w) begin
         // A reload discards anything in flight and restarts the statistics.
         state      <= LOADED;
         w1         <= w1_in;
         w2         <= w2_in;
         b          <= b_in;
         s1_v       <= 1'b0;
         s2_v       <= 1'b0;
         sample_cnt <= '0;
         pos_cnt    <= '0;
      end else begin
         if (s2_load) begin
            s2_v <= s1_v;
            if (s1_v) begin
               sum <= sum_c;
               y   <= !sum_c[2*W+1];
            end
         end
         if (s1_load) begin
            s1_v <= accept;
            if (accept) begin
               p1  <= prod1;
               p2  <= prod2;
               bsh <= bsh_c;
            end
         end
         if (handshake) begin
            if (sample_cnt != {CW{1'b1}}) sample_cnt <= sample_cnt + CW'(1);
            if (y && pos_cnt != {CW{1'b1}}) pos_cnt <= pos_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_perceptron_classifier.sv
// Directed bench for perceptron_classifier: the driver pushes hand-computed results
// into exp_q on accept; a negedge monitor pops and compares on every output handshake.
module tb_perceptron_classifier;

   localparam int W  = 14;
   localparam int CW = 16;
   localparam int SW = 2 * W + 2;

   logic          clk = 1'b0;
   logic          rst, load_w, in_valid, out_ready;
   logic [W-1:0]  w1_in, w2_in, b_in, x1, x2;
   logic          in_ready, out_valid, y, loaded;
   logic [SW-1:0] sum;
   logic [CW-1:0] sample_cnt, pos_cnt;

   logic [SW:0]   exp_q[$];
   int            checks = 0;
   int            failures = 0;
   int            exp_pos = 0;
   int            cyc = 0;
   bit            hold_pending = 1'b0;
   logic [SW:0]   held;

   // Hand-computed sums for w1=2048, w2=-1024, b=512.
   int vec_x1[8]  = '{1024, -2048, -512, 0, 100, -1000, 3000, -8192};
   int vec_x2[8]  = '{2048, 0, 0, 0, -300, 1, -8192, 8191};
   int vec_sum[8] = '{1048576, -3145728, 0, 1048576, 1560576, -1000448, 15581184, -24116224};

   perceptron_classifier dut (
      .clk(clk), .rst(rst), .load_w(load_w),
      .w1_in(w1_in), .w2_in(w2_in), .b_in(b_in),
      .in_valid(in_valid), .in_ready(in_ready), .x1(x1), .x2(x2),
      .out_valid(out_valid), .out_ready(out_ready), .y(y), .sum(sum),
      .loaded(loaded), .sample_cnt(sample_cnt), .pos_cnt(pos_cnt)
   );

   // Clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [SW:0] mk_exp(input int s);
      logic [31:0] sv;
      sv = s;
      return {(s >= 0), sv[SW-1:0]};
   endfunction

   // Driver tasks: entered and left at posedge+#1.
   task automatic load(input int a, input int c, input int bb);
      load_w = 1'b1;
      w1_in = a[W-1:0];
      w2_in = c[W-1:0];
      b_in = bb[W-1:0];
      @(posedge clk); #1;
      load_w = 1'b0;
      exp_q.delete();
      exp_pos = 0;
   endtask

   task automatic send(input int a, input int c, input int exp_sum);
      int  n = 0;
      bit  done = 1'b0;
      x1 = a[W-1:0];
      x2 = c[W-1:0];
      in_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(mk_exp(exp_sum));
            if (exp_sum >= 0) exp_pos++;
            done = 1'b1;
         end
         @(posedge clk); #1;
         n++;
         if (!done && n > 40) begin
            check("send_timeout", 64'(n), 64'(40));
            done = 1'b1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_left", 64'(exp_q.size()), 64'(0));
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!rst) begin
         hold_pending = 1'b0;
      end else begin
         if (out_valid && hold_pending) check("hold_stable", {y, sum}, held);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("out_unexpected", 64'(out_valid), 64'(0));
            else check("result", {y, sum}, exp_q.pop_front());
         end
         hold_pending = out_valid && !out_ready;
         held = {y, sum};
      end
   end

   initial begin
      int acc;
      int t0;
      rst = 1'b0; load_w = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      w1_in = '0; w2_in = '0; b_in = '0; x1 = '0; x2 = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_outputs", {in_ready, out_valid, y, loaded}, 64'(0));
      check("rst_sum", 64'(sum), 64'(0));
      check("rst_cnt", {sample_cnt, pos_cnt}, 64'(0));
      @(posedge clk); #1;
      rst = 1'b1;

      // EMPTY ignores samples
      in_valid = 1'b1; x1 = 14'd1000; x2 = 14'd1000;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("empty_ignore", {in_ready, out_valid}, 64'(0));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("empty_state", {loaded, sample_cnt, pos_cnt}, 64'(0));

      // Load and the three reference samples, with latency check on the first
      load(2048, -1024, 512);
      @(negedge clk);
      check("loaded_after_load", {loaded, in_ready}, 64'(3));
      @(posedge clk); #1;
      send(1024, 2048, 1048576);
      @(negedge clk);
      check("latency_edge1", 64'(out_valid), 64'(0));
      @(posedge clk); #1;
      @(negedge clk);
      check("latency_edge2", 64'(out_valid), 64'(1));
      check("first_sum", 64'(sum), 64'(1048576));
      @(posedge clk); #1;
      send(-2048, 0, -3145728);
      send(-512, 0, 0);
      drain();
      check("cnt_three", {sample_cnt, pos_cnt}, {32'd0, 16'd3, 16'd2});

      // Eight back-to-back samples
      load(2048, -1024, 512);
      t0 = cyc;
      for (int i = 0; i < 8; i++) send(vec_x1[i], vec_x2[i], vec_sum[i]);
      check("b2b_cycles", 64'(cyc - t0), 64'(8));
      drain();
      check("b2b_sample_cnt", 64'(sample_cnt), 64'(8));
      check("b2b_pos_cnt", 64'(pos_cnt), 64'(exp_pos));

      // Backpressure: five cycles with out_ready low
      out_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         x1 = vec_x1[3 + acc][W-1:0];
         x2 = vec_x2[3 + acc][W-1:0];
         in_valid = 1'b1;
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(mk_exp(vec_sum[3 + acc]));
            acc++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("stall_accepted", 64'(acc), 64'(2));
      out_ready = 1'b1;
      drain();
      check("stall_sample_cnt", 64'(sample_cnt), 64'(10));

      // Extreme operands
      load(-8192, -8192, 8191);
      send(-8192, -8192, 150992896);
      drain();
      check("extreme_pos", {sample_cnt, pos_cnt}, {32'd0, 16'd1, 16'd1});

      // Reload with two samples in flight
      out_ready = 1'b0;
      send(0, 0, 16775168);
      send(0, 0, 16775168);
      load(1024, 2048, -2048);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reload_flushed", 64'(out_valid), 64'(0));
         @(posedge clk); #1;
      end
      check("reload_cnt", {sample_cnt, pos_cnt}, 64'(0));
      send(1000, -500, -4194304);
      drain();
      check("reload_new_w", {sample_cnt, pos_cnt}, {32'd0, 16'd1, 16'd0});

      // Reset mid-stream
      out_ready = 1'b0;
      send(0, 0, -4194304);
      send(0, 0, -4194304);
      rst = 1'b0;
      @(posedge clk); #1;
      exp_q.delete();
      rst = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("midrst_ctrl", {in_ready, out_valid, loaded, y}, 64'(0));
         check("midrst_data", {sum, sample_cnt, pos_cnt}, 64'(0));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
